ram_arbiter: RTL

Two-port round-robin arbiter sharing one single-port `ram` instance between two requesters, e.g. a CPU fetch/load path and a DMA or debug port. It latches each granted request, drives the RAM control, address and data lines for exactly one access cycle, and captures read data into a per-port register. It returns a one-cycle acknowledge to the requester.

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of one single-port RAM.
// A granted request is latched, presented to the RAM for exactly one ACCESS
// cycle, and acknowledged with a one-cycle ack in the following DONE cycle.
// Read data is captured into a per-port output register.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   reqN_i, wrN_i                 request / write-enable from port N
//   addrN_i, data_inN_i           access address / write data from port N
//   data_outN_o                   registered read data for port N
//   ackN_o                        one-cycle completion pulse for port N
//   ram_en_o, ram_wr_o            RAM enable / write strobe
//   ram_addr_o, ram_data_in_o     latched address / write data to the RAM
//   ram_data_out_i                combinational RAM read data
module ram_arbiter #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 wr0_i,
  input  logic                 wr1_i,
  input  logic [ADDR_BITS-1:0] addr0_i,
  input  logic [ADDR_BITS-1:0] addr1_i,
  input  logic [DATA_BITS-1:0] data_in0_i,
  input  logic [DATA_BITS-1:0] data_in1_i,
  output logic [DATA_BITS-1:0] data_out0_o,
  output logic [DATA_BITS-1:0] data_out1_o,
  output logic                 ack0_o,
  output logic                 ack1_o,
  output logic                 ram_en_o,
  output logic                 ram_wr_o,
  output logic [ADDR_BITS-1:0] ram_addr_o,
  output logic [DATA_BITS-1:0] ram_data_in_o,
  input  logic [DATA_BITS-1:0] ram_data_out_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e               state_q;
  logic                 grant_q;
  logic                 last_q;
  logic                 ack0_q, ack1_q;
  logic                 ram_en_q, ram_wr_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [DATA_BITS-1:0] ram_data_q;
  logic [DATA_BITS-1:0] data_out0_q, data_out1_q;

  logic                 arb_valid;
  logic                 arb_port;
  logic                 sel_wr;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_data;

  // Arbitration: in DONE the just-served port is masked, so only the other
  // port can be granted back-to-back.
  always_comb begin
    arb_valid = 1'b0;
    arb_port  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          arb_valid = 1'b1;
          arb_port  = (req0_i && req1_i) ? ~last_q : req1_i;
        end
      end
      StDone: begin
        arb_port  = ~grant_q;
        arb_valid = grant_q ? req0_i : req1_i;
      end
      default: ;
    endcase
    sel_wr   = arb_port ? wr1_i      : wr0_i;
    sel_addr = arb_port ? addr1_i    : addr0_i;
    sel_data = arb_port ? data_in1_i : data_in0_i;
  end

  // ram_addr_q / ram_data_q double as the latched request fields; ram_wr_q is
  // the latched write flag and is only ever high during ACCESS.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      data_out0_q <= '0;
      data_out1_q <= '0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ram_en_q <= 1'b0;
      ram_wr_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (arb_valid) begin
            grant_q    <= arb_port;
            ram_addr_q <= sel_addr;
            ram_data_q <= sel_data;
            ram_wr_q   <= sel_wr;
            ram_en_q   <= 1'b1;
            state_q    <= StAccess;
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          if (!ram_wr_q) begin
            if (grant_q) data_out1_q <= ram_data_out_i;
            else         data_out0_q <= ram_data_out_i;
          end
          if (grant_q) ack1_q <= 1'b1;
          else         ack0_q <= 1'b1;
          last_q  <= grant_q;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out0_o   = data_out0_q;
  assign data_out1_o   = data_out1_q;
  assign ack0_o        = ack0_q;
  assign ack1_o        = ack1_q;
  assign ram_en_o      = ram_en_q;
  assign ram_wr_o      = ram_wr_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_data_in_o = ram_data_q;

endmodule
